// File: rtl/fp_round32_pkg.sv
// Shared types and constants for the FP32 rounding stage.
package fp_round32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 4;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp32n_t;

  localparam logic [30:0] MAX_FINITE = 31'h7F7FFFFF;
  localparam logic [30:0] INF        = 31'h7F800000;

  // Encodings 5-7 are reserved and fall back to round-to-nearest-even.
  function automatic rm_e rm_decode(input logic [2:0] raw);
    rm_decode = (raw > 3'd4) ? RM_RNE : rm_e'(raw);
  endfunction

endpackage

// File: rtl/fp_round32_decide.sv
// Round-up decision from sign, LSB, guard and combined round/sticky.
module fp_round32_decide
  import fp_round32_pkg::*;
(
  input  logic sign,
  input  logic lsb,
  input  logic g,
  input  logic rs,
  input  rm_e  rm,
  output logic round_up
);

  always_comb begin
    round_up = 1'b0;
    case (rm)
      RM_RNE:  round_up = g & (rs | lsb);
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = sign & (g | rs);
      RM_RUP:  round_up = ~sign & (g | rs);
      RM_RMM:  round_up = g;
      default: round_up = g & (rs | lsb);
    endcase
  end

endmodule

// File: rtl/fp_round32.sv
// Two-stage rounding pipeline between the FP32N normaliser and the result bus.
// Stage 1 decides the round-up bit; stage 2 applies it and forms the flags.
module fp_round32
  import fp_round32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [35:0] in_num,
  input  logic [2:0]  in_rm,
  input  logic        in_under,
  input  logic        in_inexact,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_num,
  output logic        out_inexact,
  output logic        out_overflow,
  output logic        out_underflow
);

  fp32n_t            num;
  rm_e               rm_in;
  logic              adv1, adv2, load1, load2;
  logic              up_in, special_in, zero_in;
  logic [FRAC_W-1:0] frac_in;

  logic              v1_q, v1_d, v2_q, v2_d;
  logic              sign1_q, sign1_d;
  logic [EXP_W-1:0]  exp1_q, exp1_d;
  logic [FRAC_W-1:0] frac1_q, frac1_d;
  logic              up1_q, up1_d;
  rm_e               rm1_q, rm1_d;
  logic              spec1_q, spec1_d;
  logic              zero1_q, zero1_d;
  logic              inx1_q, inx1_d;
  logic              under1_q, under1_d;

  logic [31:0]       num2_q, num2_d;
  logic              inx2_q, inx2_d;
  logic              ovf2_q, ovf2_d;
  logic              unf2_q, unf2_d;

  logic [30:0]       sum;
  logic [30:0]       ovf_mag;
  logic              ovf;

  assign num      = fp32n_t'(in_num);
  assign adv2     = ~v2_q | out_ready;
  assign adv1     = ~v1_q | adv2;
  assign in_ready = adv1;
  assign load1    = in_valid & adv1;
  assign load2    = v1_q & adv2;

  fp_round32_decide u_decide (
    .sign     (num.sign),
    .lsb      (num.sig[3]),
    .g        (num.sig[2]),
    .rs       (num.sig[1] | num.sig[0]),
    .rm       (rm_in),
    .round_up (up_in)
  );

  always_comb begin
    rm_in      = rm_decode(in_rm);
    special_in = (num.exp == '1);
    zero_in    = (num.exp == '0) && (num.sig == '0);
    frac_in    = num.sig[FRAC_W+2:3];
    // Quiet any NaN on the way through.
    if (special_in && (frac_in != '0)) frac_in[FRAC_W-1] = 1'b1;
  end

  always_comb begin
    v1_d     = adv1 ? in_valid : v1_q;
    sign1_d  = sign1_q;
    exp1_d   = exp1_q;
    frac1_d  = frac1_q;
    up1_d    = up1_q;
    rm1_d    = rm1_q;
    spec1_d  = spec1_q;
    zero1_d  = zero1_q;
    inx1_d   = inx1_q;
    under1_d = under1_q;
    if (load1) begin
      sign1_d  = num.sign;
      exp1_d   = num.exp;
      frac1_d  = frac_in;
      up1_d    = up_in & ~special_in;
      rm1_d    = rm_in;
      spec1_d  = special_in;
      zero1_d  = zero_in;
      inx1_d   = (num.sig[2] | num.sig[1] | num.sig[0] | in_inexact) & ~special_in;
      under1_d = in_under;
    end
  end

  // Carry out of the fraction bumps the exponent, including denormal -> 2^-126.
  always_comb begin
    sum = {exp1_q, frac1_q} + {30'd0, up1_q};
    ovf = ~spec1_q & (sum[30:23] == 8'hFF);
    case (rm1_q)
      RM_RTZ:  ovf_mag = MAX_FINITE;
      RM_RDN:  ovf_mag = sign1_q ? INF : MAX_FINITE;
      RM_RUP:  ovf_mag = sign1_q ? MAX_FINITE : INF;
      default: ovf_mag = INF;
    endcase
  end

  always_comb begin
    v2_d   = adv2 ? v1_q : v2_q;
    num2_d = num2_q;
    inx2_d = inx2_q;
    ovf2_d = ovf2_q;
    unf2_d = unf2_q;
    if (load2) begin
      num2_d = {sign1_q, sum};
      inx2_d = inx1_q;
      ovf2_d = 1'b0;
      unf2_d = under1_q & inx1_q;
      if (spec1_q) begin
        num2_d = {sign1_q, 8'hFF, frac1_q};
        inx2_d = 1'b0;
        unf2_d = 1'b0;
      end else if (zero1_q) begin
        num2_d = {sign1_q, 31'd0};
        inx2_d = 1'b0;
        unf2_d = 1'b0;
      end else if (ovf) begin
        num2_d = {sign1_q, ovf_mag};
        inx2_d = 1'b1;
        ovf2_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      sign1_q  <= 1'b0;
      exp1_q   <= '0;
      frac1_q  <= '0;
      up1_q    <= 1'b0;
      rm1_q    <= RM_RNE;
      spec1_q  <= 1'b0;
      zero1_q  <= 1'b0;
      inx1_q   <= 1'b0;
      under1_q <= 1'b0;
      num2_q   <= '0;
      inx2_q   <= 1'b0;
      ovf2_q   <= 1'b0;
      unf2_q   <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      sign1_q  <= sign1_d;
      exp1_q   <= exp1_d;
      frac1_q  <= frac1_d;
      up1_q    <= up1_d;
      rm1_q    <= rm1_d;
      spec1_q  <= spec1_d;
      zero1_q  <= zero1_d;
      inx1_q   <= inx1_d;
      under1_q <= under1_d;
      num2_q   <= num2_d;
      inx2_q   <= inx2_d;
      ovf2_q   <= ovf2_d;
      unf2_q   <= unf2_d;
    end
  end

  assign out_valid     = v2_q;
  assign out_num       = num2_q;
  assign out_inexact   = inx2_q;
  assign out_overflow  = ovf2_q;
  assign out_underflow = unf2_q;

endmodule
